// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC core decode stage.
//   - opcode encodings (opc_e)
//   - default field widths and instruction field bit positions
//   - decoded_t: one decoded instruction as carried through the stage
package riscv_pkg;

  localparam int unsigned XLEN      = 32;  // instruction / immediate width
  localparam int unsigned OPC_BITS  = 6;   // opcode field width
  localparam int unsigned OPS_LEGAL = 25;  // legal opcodes 0..OPS_LEGAL-1
  localparam int unsigned REG_BITS  = 5;   // register specifier width
  localparam int unsigned IMM_BITS  = 16;  // immediate field width

  // Register field LSB positions within the instruction word
  localparam int unsigned RD_LSB  = 21;
  localparam int unsigned RS1_LSB = 16;
  localparam int unsigned RS2_LSB = 11;

  typedef enum logic [OPC_BITS-1:0] {
    OPC_NOP  = 6'h00,
    OPC_ADD  = 6'h01,
    OPC_SUB  = 6'h02,
    OPC_AND  = 6'h03,
    OPC_OR   = 6'h04,
    OPC_XOR  = 6'h05,
    OPC_NOT  = 6'h06,
    OPC_LD   = 6'h07,
    OPC_ST   = 6'h08,
    OPC_BEQ  = 6'h09,
    OPC_BNE  = 6'h0A,
    OPC_BLT  = 6'h0B,
    OPC_JMP  = 6'h0C,
    OPC_JAL  = 6'h0D,
    OPC_JR   = 6'h0E,
    OPC_MUL  = 6'h0F,
    OPC_DIV  = 6'h10,
    OPC_SLI  = 6'h11,
    OPC_SRI  = 6'h12,
    OPC_ADDI = 6'h13,
    OPC_ANDI = 6'h14,
    OPC_ORI  = 6'h15,
    OPC_ADDF = 6'h16,
    OPC_SUBF = 6'h17,
    OPC_MULF = 6'h18
  } opc_e;

  typedef struct packed {
    logic [OPS_LEGAL-2:0] onehot;
    logic                 nop;
    logic                 illegal;
    logic [REG_BITS-1:0]  rd;
    logic [REG_BITS-1:0]  rs1;
    logic [REG_BITS-1:0]  rs2;
    logic [XLEN-1:0]      imm;
  } decoded_t;

endpackage

// File: rtl/opc_decode_stage_if.sv
// Handshake bus of the decode stage.
//   in_valid/in_ready/in_instr : instruction input from fetch
//   out_valid/out_ready/out_*  : decoded entry towards register-read
// slave modport: the decode stage; master modport: fetch/downstream side.
interface opc_decode_stage_if #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned NUM_OPS = 25,
  parameter int unsigned REG_W   = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [NUM_OPS-2:0] out_onehot;
  logic               out_nop;
  logic               out_illegal;
  logic [REG_W-1:0]   out_rd;
  logic [REG_W-1:0]   out_rs1;
  logic [REG_W-1:0]   out_rs2;
  logic [INSTR_W-1:0] out_imm;

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_onehot, out_nop, out_illegal,
           out_rd, out_rs1, out_rs2, out_imm
  );

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_onehot, out_nop, out_illegal,
           out_rd, out_rs1, out_rs2, out_imm
  );
endinterface

// File: rtl/opc_decode_comb.sv
// Pure combinational opcode decoder.
//   instr : raw instruction word
//   dec   : one-hot op select, nop/illegal flags, register fields and the
//           extended immediate (zero-extended for sli/sri, sign-extended else)
module opc_decode_comb
  import riscv_pkg::*;
#(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned OPC_W   = 6,
  parameter int unsigned NUM_OPS = 25,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned IMM_W   = 16
) (
  input  logic [INSTR_W-1:0] instr,
  output decoded_t           dec
);

  logic [OPC_W-1:0]   opc;
  logic [IMM_W-1:0]   imm;
  logic [NUM_OPS-2:0] onehot;

  assign opc = instr[INSTR_W-1 -: OPC_W];
  assign imm = instr[IMM_W-1:0];

  // Bit i selects opcode i+1; nop shares bit 0 because it executes as add.
  for (genvar g = 0; g < NUM_OPS - 1; g++) begin : g_onehot
    if (g == 0) begin : g_add
      assign onehot[g] = (opc == OPC_ADD) || (opc == OPC_NOP);
    end else begin : g_op
      assign onehot[g] = (32'(opc) == 32'(g + 1));
    end
  end

  always_comb begin
    dec         = '0;
    dec.onehot  = onehot;
    dec.nop     = (opc == OPC_NOP);
    dec.illegal = (32'(opc) >= NUM_OPS);
    dec.rd      = instr[RD_LSB  +: REG_W];
    dec.rs1     = instr[RS1_LSB +: REG_W];
    dec.rs2     = instr[RS2_LSB +: REG_W];
    if (opc == OPC_SLI || opc == OPC_SRI) begin
      dec.imm = {{(INSTR_W-IMM_W){1'b0}}, imm};
    end else begin
      dec.imm = {{(INSTR_W-IMM_W){imm[IMM_W-1]}}, imm};
    end
  end

endmodule

// File: rtl/opc_decode_stage.sv
// Registered opcode decode stage with a 2-entry skid buffer.
//   clk, rst      : clock, asynchronous active-high reset
//   flush         : synchronous flush, discards all held entries
//   bus           : slave side of the decode handshake bus
//   illegal_count : saturating count of accepted illegal opcodes
// M drives the outputs; S catches the one instruction that arrives while M
// is stalled, which lets in_ready be a flop with no path from out_ready.
module opc_decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned OPC_W   = 6,
  parameter int unsigned NUM_OPS = 25,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  opc_decode_stage_if.slave     bus,
  output logic [CNT_W-1:0]      illegal_count
);

  decoded_t         dec;
  decoded_t         m_data_q, m_data_d;
  decoded_t         s_data_q, s_data_d;
  logic             m_valid_q, m_valid_d;
  logic             s_valid_q, s_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             m_xfer;

  opc_decode_comb #(
    .INSTR_W (INSTR_W),
    .OPC_W   (OPC_W),
    .NUM_OPS (NUM_OPS),
    .REG_W   (REG_W),
    .IMM_W   (IMM_W)
  ) u_dec (
    .instr (bus.in_instr),
    .dec   (dec)
  );

  assign accept = bus.in_valid & in_ready_q;
  assign m_xfer = m_valid_q & bus.out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    cnt_d     = cnt_q;

    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else begin
      // in_ready is low whenever S is valid, so the S->M refill never
      // coincides with an accept.
      if (m_xfer && s_valid_q) begin
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else if (accept && (!m_valid_q || m_xfer)) begin
        m_valid_d = 1'b1;
        m_data_d  = dec;
      end else if (accept) begin
        s_valid_d = 1'b1;
        s_data_d  = dec;
      end else if (m_xfer) begin
        m_valid_d = 1'b0;
      end

      if (accept && dec.illegal && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    in_ready_d = ~s_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
      m_data_q   <= '0;
      s_data_q   <= '0;
      cnt_q      <= '0;
    end else begin
      m_valid_q  <= m_valid_d;
      s_valid_q  <= s_valid_d;
      in_ready_q <= in_ready_d;
      m_data_q   <= m_data_d;
      s_data_q   <= s_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = m_valid_q;
  assign bus.out_onehot  = m_data_q.onehot;
  assign bus.out_nop     = m_data_q.nop;
  assign bus.out_illegal = m_data_q.illegal;
  assign bus.out_rd      = m_data_q.rd;
  assign bus.out_rs1     = m_data_q.rs1;
  assign bus.out_rs2     = m_data_q.rs2;
  assign bus.out_imm     = m_data_q.imm;
  assign illegal_count   = cnt_q;

endmodule

// File: tb/tb_opc_decode_stage.sv
// Directed bench for opc_decode_stage: streaming decode, immediate
// extension, illegal counting with saturation, skid stall/drain, flush and
// asynchronous reset.
module tb_opc_decode_stage;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [7:0] illegal_count;

  int checks   = 0;
  int failures = 0;

  opc_decode_stage_if #(.INSTR_W(32), .NUM_OPS(25), .REG_W(5)) bus ();

  opc_decode_stage #(
    .INSTR_W (32),
    .OPC_W   (6),
    .NUM_OPS (25),
    .REG_W   (5),
    .IMM_W   (16),
    .CNT_W   (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .bus           (bus),
    .illegal_count (illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] opc, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [15:0] imm);
    return {opc, rd, rs1, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_cnt;

    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_onehot",    32'(bus.out_onehot), 32'd0);
    chk("rst_imm",       bus.out_imm,         32'd0);
    chk("rst_rd",        32'(bus.out_rd),     32'd0);
    chk("rst_count",     32'(illegal_count),  32'd0);
    step();
    rst = 1'b0;

    // Stream nop, add, mulf back to back
    bus.in_valid = 1'b1;
    bus.in_instr = mk(6'h00, 5'd1, 5'd2, 16'h1234);
    step();
    chk("nop_valid",   32'(bus.out_valid),   32'd1);
    chk("nop_onehot",  32'(bus.out_onehot),  32'h000001);
    chk("nop_flag",    32'(bus.out_nop),     32'd1);
    chk("nop_illegal", 32'(bus.out_illegal), 32'd0);
    chk("nop_rd",      32'(bus.out_rd),      32'd1);
    chk("nop_rs1",     32'(bus.out_rs1),     32'd2);
    chk("nop_rs2",     32'(bus.out_rs2),     32'd2);
    chk("nop_imm",     bus.out_imm,          32'h00001234);
    bus.in_instr = mk(6'h01, 5'd5, 5'd6, 16'h0000);
    step();
    chk("add_valid",  32'(bus.out_valid),  32'd1);
    chk("add_onehot", 32'(bus.out_onehot), 32'h000001);
    chk("add_nop",    32'(bus.out_nop),    32'd0);
    chk("add_rd",     32'(bus.out_rd),     32'd5);
    bus.in_instr = mk(6'h18, 5'd31, 5'd0, 16'h8000);
    step();
    chk("mulf_onehot",  32'(bus.out_onehot),  32'h800000);
    chk("mulf_illegal", 32'(bus.out_illegal), 32'd0);
    chk("mulf_rd",      32'(bus.out_rd),      32'd31);
    chk("mulf_rs2",     32'(bus.out_rs2),     32'd16);
    chk("mulf_imm",     bus.out_imm,          32'hFFFF8000);
    bus.in_valid = 1'b0;
    step();
    chk("drain_valid", 32'(bus.out_valid), 32'd0);

    // Immediate extension
    bus.in_valid = 1'b1;
    bus.in_instr = mk(6'h13, 5'd0, 5'd0, 16'hFFF0);
    step();
    chk("addi_imm",    bus.out_imm,         32'hFFFFFFF0);
    chk("addi_onehot", 32'(bus.out_onehot), 32'h040000);
    bus.in_instr = mk(6'h11, 5'd0, 5'd0, 16'h8001);
    step();
    chk("sli_imm",    bus.out_imm,         32'h00008001);
    chk("sli_onehot", 32'(bus.out_onehot), 32'h010000);
    bus.in_instr = mk(6'h12, 5'd3, 5'd4, 16'hFFFF);
    step();
    chk("sri_imm",    bus.out_imm,         32'h0000FFFF);
    chk("sri_onehot", 32'(bus.out_onehot), 32'h020000);
    chk("sri_rs1",    32'(bus.out_rs1),    32'd4);

    // Illegal opcode 0x3F accepted 300 times; counter saturates at 255
    bus.in_instr = mk(6'h3F, 5'd0, 5'd0, 16'h0000);
    for (int i = 0; i < 300; i++) begin
      step();
      exp_cnt = (i + 1 > 255) ? 255 : i + 1;
      chk("ill_flag",   32'(bus.out_illegal), 32'd1);
      chk("ill_onehot", 32'(bus.out_onehot),  32'd0);
      chk("ill_count",  32'(illegal_count),   32'(exp_cnt));
    end
    // First illegal opcode just past the legal range
    bus.in_instr = mk(6'h19, 5'd0, 5'd0, 16'h0000);
    step();
    chk("b19_illegal", 32'(bus.out_illegal), 32'd1);
    chk("b19_onehot",  32'(bus.out_onehot),  32'd0);
    chk("b19_count",   32'(illegal_count),   32'd255);
    bus.in_valid = 1'b0;
    step();

    // Stall: continuous in_valid with out_ready low for 4 cycles
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = mk(6'h02, 5'd1, 5'd1, 16'h0001);
    step();
    chk("stall_a_onehot", 32'(bus.out_onehot), 32'h000002);
    chk("stall_rdy1",     32'(bus.in_ready),   32'd1);
    bus.in_instr = mk(6'h03, 5'd2, 5'd2, 16'h0002);
    step();
    chk("stall_rdy2",   32'(bus.in_ready),   32'd0);
    chk("stall_hold_a", 32'(bus.out_onehot), 32'h000002);
    bus.in_instr = mk(6'h04, 5'd3, 5'd3, 16'h0003);
    step();
    chk("stall_rdy3",  32'(bus.in_ready), 32'd0);
    chk("stall_imm_a", bus.out_imm,       32'h00000001);
    step();
    chk("stall_rdy4",  32'(bus.in_ready),   32'd0);
    chk("stall_valid", 32'(bus.out_valid),  32'd1);
    chk("stall_rd_a",  32'(bus.out_rd),     32'd1);
    bus.out_ready = 1'b1;
    step();
    chk("drain_b_onehot", 32'(bus.out_onehot), 32'h000004);
    chk("drain_b_imm",    bus.out_imm,         32'h00000002);
    chk("drain_rdy",      32'(bus.in_ready),   32'd1);
    step();
    chk("drain_c_onehot", 32'(bus.out_onehot), 32'h000008);
    chk("drain_c_rd",     32'(bus.out_rd),     32'd3);
    bus.in_valid = 1'b0;
    step();
    chk("drain_empty", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset between edges while an entry is held
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = mk(6'h18, 5'd7, 5'd0, 16'h0000);
    step();
    chk("pre_rst_valid", 32'(bus.out_valid),  32'd1);
    chk("pre_rst_count", 32'(illegal_count),  32'd255);
    bus.in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid",  32'(bus.out_valid),  32'd0);
    chk("arst_onehot", 32'(bus.out_onehot), 32'd0);
    chk("arst_count",  32'(illegal_count),  32'd0);
    chk("arst_rdy",    32'(bus.in_ready),   32'd1);
    #1;
    rst = 1'b0;
    step();

    // Fill M and S with illegals, then flush with an illegal presented
    bus.in_valid = 1'b1;
    bus.in_instr = mk(6'h3F, 5'd0, 5'd0, 16'h0000);
    step();
    chk("fill_count1", 32'(illegal_count), 32'd1);
    bus.in_instr = mk(6'h20, 5'd0, 5'd0, 16'h0000);
    step();
    chk("fill_count2", 32'(illegal_count), 32'd2);
    chk("fill_rdy",    32'(bus.in_ready),  32'd0);
    bus.in_instr = mk(6'h3E, 5'd0, 5'd0, 16'h0000);
    flush = 1'b1;
    step();
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_rdy",   32'(bus.in_ready),  32'd1);
    chk("flush_count", 32'(illegal_count), 32'd2);
    // Accept during a flush cycle is discarded and not counted
    bus.in_instr = mk(6'h30, 5'd0, 5'd0, 16'h0000);
    step();
    chk("flush_acc_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_acc_count", 32'(illegal_count), 32'd2);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    step();
    chk("post_flush_valid", 32'(bus.out_valid), 32'd0);

    // Normal operation resumes
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = mk(6'h07, 5'd9, 5'd10, 16'h7FFF);
    step();
    chk("resume_valid",  32'(bus.out_valid),  32'd1);
    chk("resume_onehot", 32'(bus.out_onehot), 32'h000040);
    chk("resume_imm",    bus.out_imm,         32'h00007FFF);
    chk("resume_count",  32'(illegal_count),  32'd2);
    bus.in_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/opc_decode_stage.md
Name: opc_decode_stage

Overview:
- Registered, parametrised successor to the combinational opcode decoder of the 32-bit RISC core; sits between fetch and register-read/execute.
- Accepts one 32-bit instruction per cycle over a valid/ready handshake and decodes the opcode to a one-hot operation vector.
- Extracts register fields, produces an extended immediate and flags illegal opcodes.
- Contains a 2-entry skid buffer so that in_ready is a registered signal, with no combinational path from out_ready.

Parameters:
- INSTR_W, 32, instruction and immediate-output width.
- OPC_W, 6, opcode field width, at instr[INSTR_W-1 -: OPC_W].
- NUM_OPS, 25, number of legal opcodes (0..NUM_OPS-1). One-hot width is NUM_OPS-1.
- REG_W, 5, register-specifier width.
- IMM_W, 16, immediate field width, at instr[IMM_W-1:0].
- CNT_W, 8, illegal-opcode counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  instruction valid.
- in_ready  out  1  stage can accept; registered.
- in_instr  in  INSTR_W  raw instruction.
- out_valid  out  1  decoded entry valid.
- out_ready  in  1  downstream accepts.
- out_onehot  out  NUM_OPS-1  one-hot operation select.
- out_nop  out  1  opcode 0.
- out_illegal  out  1  opcode >= NUM_OPS.
- out_rd, out_rs1, out_rs2  out  REG_W each  fields at [25:21], [20:16], [15:11].
- out_imm  out  INSTR_W  extended immediate.
- illegal_count  out  CNT_W  saturating count of accepted illegal opcodes.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, skid valid=0, in_ready=1.
  - All out_* data fields 0; illegal_count=0.
- Decode (combinational on in_instr, captured at accept; opc is the opcode field):
  - opc=0 (nop): onehot bit0 set (nop executes as add), out_nop=1.
  - 1<=opc<NUM_OPS: onehot bit opc-1 set, all other bits 0.
  - opc>=NUM_OPS: onehot all 0, out_illegal=1.
  - Exactly one of {one-hot bit, out_illegal} is set for every valid output.
- Immediate extension:
  - opc 0x11 (sli) and 0x12 (sri): zero-extend imm field to INSTR_W.
  - All other opcodes: sign-extend.
  - Register fields pass through unchanged regardless of opcode.
- Handshake:
  - accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
  - Latency: an instruction accepted at edge N is presented at out_* after edge N (visible in cycle N+1). Throughput is 1 per cycle.
- Storage: main register M (drives out_*) and skid register S.
  - accept when M empty, or M transferring this cycle with S empty: load M.
  - accept while M full and not transferring: load S.
  - M transferring and S valid: M<=S, S cleared. A same-cycle accept is impossible because in_ready=0 whenever S is valid.
  - in_ready is the registered complement of next-state S valid.
- Ordering: strict FIFO order; no entry is dropped or duplicated. Output data are held stable while out_valid=1 and out_ready=0.
- Flush:
  - Clears M and S valid at the edge; in_ready=1 next cycle.
  - An accept in the flush cycle is discarded and does not count toward illegal_count.
  - Flush has priority over every other update.
- illegal_count:
  - Increments on accept of an illegal opcode when flush=0.
  - Saturates at 2^CNT_W-1; cleared only by rst.
- Reset mid-operation discards all entries immediately (async).

Decomposition:
- Package riscv_pkg holds:
  - opcode localparams (OPC_NOP=0x00, OPC_ADD=0x01 ... OPC_MULF=0x18);
  - the instruction field bit positions;
  - a packed struct decoded_t {onehot, nop, illegal, rd, rs1, rs2, imm}.
- Natural sub-module opc_decode_comb: a pure function of in_instr producing decoded_t, instantiated once ahead of the skid logic. The stage itself holds only storage, handshake and the counter.

Test Plan:
- Reset, then opcodes 0x00, 0x01, 0x18 streamed with out_ready=1 -> one output per cycle, 1-cycle latency. Onehot = 0x000001, 0x000001 (out_nop=1 only on the first), 0x800000.
- instr with opcode 0x13 (addi), imm=0xFFF0 -> out_imm=0xFFFFFFF0. Opcode 0x11 (sli), imm=0x8001 -> out_imm=0x00008001.
- Opcode 0x3F accepted 300 times -> out_illegal=1 and onehot=0 each time; illegal_count ends at 255 (saturated).
- Continuous in_valid while out_ready=0 for 4 cycles:
  - two entries accepted, in_ready=0 from the cycle after the second accept;
  - on release, entries drain in order, in_ready returns to 1, no loss.
- flush asserted with M and S full and an illegal instruction presented -> out_valid=0 next cycle, in_ready=1, illegal_count unchanged.
- rst pulsed asynchronously between clock edges while out_valid=1 -> out_valid, out_onehot and illegal_count all go to 0 immediately without a clock edge.
